// File: rtl/dlock_pkg.sv
// dlock_pkg: state encoding and code length shared by the entry framer and the serial lock
package dlock_pkg;

    localparam int DLOCK_CODE_LEN = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } dlock_state_e;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser plus saturating stable-high counter; emits one press pulse per high period
module key_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic clear,
    input  logic key,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic          sync1_q, sync2_q;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Saturating at DEBOUNCE_CYC is what limits a long hold to a single pulse
    always_comb begin
        cnt_d   = !sync2_q ? '0 : (cnt_q == CW'(DEBOUNCE_CYC)) ? cnt_q : cnt_q + 1'b1;
        press_d = sync2_q && cnt_q == CW'(DEBOUNCE_CYC - 1);
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= key;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/dlock_entry_framer.sv
// dlock_entry_framer: debounced two-key code entry, framed as a clear pulse plus an MSB-first serial burst.
// Optional partial-entry timeout enabled by defining DLOCK_ENTRY_TIMEOUT_EN.
module dlock_entry_framer import dlock_pkg::*; #(
    parameter int CODE_LEN     = DLOCK_CODE_LEN,
    parameter int DEBOUNCE_CYC = 4,
    parameter int TIMEOUT_CYC  = 255
) (
    input  logic                          clk,
    input  logic                          clear,
    input  logic                          key0,
    input  logic                          key1,
    output logic                          b_out,
    output logic                          dl_clear,
    output logic                          busy,
    output logic [$clog2(CODE_LEN+1)-1:0] digits
);
    localparam int DW = $clog2(CODE_LEN + 1);
    localparam int SW = $clog2(CODE_LEN);

    if (CODE_LEN < 2 || DEBOUNCE_CYC < 2 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("dlock_entry_framer: illegal parameter values");
    end

    logic press0, press1, accept;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key0 (
        .clk   (clk),
        .clear (clear),
        .key   (key0),
        .press (press0)
    );

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key1 (
        .clk   (clk),
        .clear (clear),
        .key   (key1),
        .press (press1)
    );

    dlock_state_e        state_q, state_d;
    logic [CODE_LEN-1:0] shift_q, shift_d;
    logic [DW-1:0]       digits_q, digits_d;
    logic [SW-1:0]       sel_q, sel_d;
    logic                b_out_q, b_out_d;
    logic                dl_clear_q, dl_clear_d;
    logic                busy_q, busy_d;
    logic                expire;

    // Coincident pulses are ambiguous, so only exactly one key counts
    assign accept = state_q == IDLE && (press0 ^ press1);

`ifdef DLOCK_ENTRY_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] idle_q, idle_d;

    always_comb begin
        expire = state_q == IDLE && digits_q != '0 && !accept && idle_q == TW'(TIMEOUT_CYC - 1);
        idle_d = (state_q == IDLE && digits_q != '0 && !accept && !expire) ? idle_q + 1'b1 : '0;
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        digits_d = digits_q;
        sel_d    = sel_q;
        case (state_q)
            IDLE: begin
                if (expire) begin
                    shift_d  = '0;
                    digits_d = '0;
                end else if (accept) begin
                    shift_d  = {shift_q[CODE_LEN-2:0], press1};
                    digits_d = digits_q + 1'b1;
                    if (digits_q == DW'(CODE_LEN - 1)) state_d = CLR;
                end
            end
            CLR: begin
                state_d = SEND;
                sel_d   = '0;
            end
            SEND: begin
                shift_d = shift_q << 1;
                sel_d   = sel_q + 1'b1;
                if (sel_q == SW'(CODE_LEN - 1)) state_d = DONE;
            end
            DONE: begin
                state_d  = IDLE;
                shift_d  = '0;
                digits_d = '0;
            end
        endcase
        // Outputs are registered from the next state; the MSB of shift_d is the bit for that SEND cycle
        b_out_d    = state_d == SEND && shift_d[CODE_LEN-1];
        dl_clear_d = state_d != CLR;
        busy_d     = state_d == CLR || state_d == SEND;
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            digits_q   <= '0;
            sel_q      <= '0;
            b_out_q    <= 1'b0;
            dl_clear_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            digits_q   <= digits_d;
            sel_q      <= sel_d;
            b_out_q    <= b_out_d;
            dl_clear_q <= dl_clear_d;
            busy_q     <= busy_d;
        end
    end

    assign b_out    = b_out_q;
    assign dl_clear = dl_clear_q;
    assign busy     = busy_q;
    assign digits   = digits_q;

endmodule

// File: tb/tb_dlock_entry_framer.sv
// tb_dlock_entry_framer: directed and randomized key entry checked against a queue-based model of entered codes and bursts
module tb_dlock_entry_framer;
    localparam int L = 6;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic       key0 = 1'b0;
    logic       key1 = 1'b0;
    logic       b_out, dl_clear, busy;
    logic [2:0] digits;

    int tests = 0;
    int fails = 0;

    dlock_entry_framer #(.CODE_LEN(L), .DEBOUNCE_CYC(D), .TIMEOUT_CYC(20)) dut (
        .clk      (clk),
        .clear    (clear),
        .key0     (key0),
        .key1     (key1),
        .b_out    (b_out),
        .dl_clear (dl_clear),
        .busy     (busy),
        .digits   (digits)
    );

    always #5 clk = ~clk;

    // Burst observer: a CLR cycle followed by the busy cycles that carry bits
    bit in_b = 0;
    int cur = 0, cur_len = 0, clr_n = 0, stray_b = 0, stray_clr = 0;
    int bursts[$];
    int blens[$];

    always @(negedge clk) begin
        if (clear && b_out === 1'b1 && !(busy === 1'b1 && dl_clear === 1'b1)) stray_b++;
        if (clear && dl_clear === 1'b0 && busy !== 1'b1) stray_clr++;
        if (!clear) in_b = 0;
        else if (dl_clear === 1'b0 && busy === 1'b1 && !in_b) begin
            clr_n++;
            in_b = 1;
            cur = 0;
            cur_len = 0;
        end else if (in_b && busy === 1'b1 && dl_clear === 1'b1) begin
            cur = (cur << 1) | int'(b_out);
            cur_len++;
        end else if (in_b) begin
            bursts.push_back(cur);
            blens.push_back(cur_len);
            in_b = 0;
        end
    end

    // Reference model: bits entered so far, and the codes that must have been sent
    int code_q[$];
    int exp_bursts[$];
    int exp_clr = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic k0, input logic k1, input int n);
        key0 = k0;
        key1 = k1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_press(input logic b);
        int v;
        code_q.push_back(int'(b));
        if (code_q.size() == L) begin
            v = 0;
            foreach (code_q[i]) v = (v << 1) | code_q[i];
            exp_bursts.push_back(v);
            exp_clr++;
            code_q.delete();
        end
    endtask

    task automatic press(input logic b, input int h, input int g);
        drive(!b, b, h);
        drive(1'b0, 1'b0, g);
        model_press(b);
        if (code_q.size() == 0) drive(1'b0, 1'b0, 12);
        @(negedge clk);
        check("digits_after_press", digits, code_q.size());
        @(posedge clk);
        #1;
    endtask

    task automatic rand_press();
        press(1'($urandom_range(0, 1)), $urandom_range(4, 10), $urandom_range(4, 10));
    endtask

    task automatic check_bursts();
        check("burst_count", bursts.size(), exp_bursts.size());
        check("clr_count", clr_n, exp_clr);
        if (bursts.size() > 0 && exp_bursts.size() > 0) begin
            check("burst_bits", bursts[$], exp_bursts[$]);
            check("burst_len", blens[$], L);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n;
        logic r;
        logic [L-1:0] pat;
        repeat (3) @(negedge clk);
        check("rst_b_out", b_out, 0);
        check("rst_dl_clear", dl_clear, 0);
        check("rst_busy", busy, 0);
        check("rst_digits", digits, 0);
        #1 clear = 1'b1;
        @(negedge clk);
        check("release_dl_clear", dl_clear, 1);
        check("release_busy", busy, 0);
        @(posedge clk);
        #1;

        // Fixed code 1,0,1,1,0,0 then random codes
        pat = 6'b101100;
        for (int i = L - 1; i >= 0; i--) press(pat[i], 8, 8);
        check_bursts();
        repeat (3) begin
            repeat (L) rand_press();
            check_bursts();
        end

        // Bounce never reaches the debounce count; a clean hold after it does
        drive(1'b0, 1'b1, 2);
        drive(1'b0, 1'b0, 1);
        drive(1'b0, 1'b1, 3);
        drive(1'b0, 1'b0, 10);
        @(negedge clk);
        check("bounce_digits", digits, code_q.size());
        @(posedge clk);
        #1;
        press(1'b1, 6, 8);

        // Both keys together are rejected; a long hold is a single press
        drive(1'b1, 1'b1, 8);
        drive(1'b0, 1'b0, 10);
        @(negedge clk);
        check("both_keys_digits", digits, code_q.size());
        @(posedge clk);
        #1;
        press(1'b0, 20, 8);
        k = L - 1 - code_q.size();
        repeat (k) rand_press();

        // Last press, then key0 pulses during SEND and is held past DONE
        drive(1'b0, 1'b1, 4);
        drive(1'b1, 1'b1, 4);
        drive(1'b1, 1'b0, 12);
        drive(1'b0, 1'b0, 8);
        model_press(1'b1);
        @(negedge clk);
        check("send_press_digits", digits, code_q.size());
        check_bursts();
        @(posedge clk);
        #1;

        // Reset in SEND cycle 3 aborts the burst
        repeat (L - 1) rand_press();
        r = 1'($urandom_range(0, 1));
        key0 = !r;
        key1 = r;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(busy === 1'b1 && dl_clear === 1'b1) && n < 40);
        check("send_reached", n < 40, 1);
        repeat (3) @(negedge clk);
        #2 clear = 1'b0;
        #1;
        check("abort_b_out", b_out, 0);
        check("abort_dl_clear", dl_clear, 0);
        check("abort_busy", busy, 0);
        check("abort_digits", digits, 0);
        key0 = 1'b0;
        key1 = 1'b0;
        code_q.delete();
        exp_clr++;
        repeat (2) @(negedge clk);
        #1 clear = 1'b1;
        @(negedge clk);
        check("abort_release_dl_clear", dl_clear, 1);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 30);
        @(negedge clk);
        check("abort_no_resend_busy", busy, 0);
        check_bursts();
        @(posedge clk);
        #1;

        // Partial entry left idle
        repeat (3) rand_press();
        drive(1'b0, 1'b0, 25);
`ifdef DLOCK_ENTRY_TIMEOUT_EN
        code_q.delete();
`endif
        @(negedge clk);
        check("idle_digits", digits, code_q.size());
        @(posedge clk);
        #1;
        k = L - code_q.size();
        repeat (k) rand_press();
        check_bursts();

        check("stray_b_out", stray_b, 0);
        check("stray_dl_clear", stray_clr, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dlock_entry_framer.md
Name: dlock_entry_framer

Overview:
Upstream feeder for the serial digital-lock FSM. Debounces two raw push-buttons (key0 = bit 0, key1 = bit 1) and collects CODE_LEN presses into a shift register. It then frames one burst for the lock: one cycle of active-low lock clear, followed by the code serialised one bit per clock, first-pressed bit first. It makes human-rate button entry compatible with a lock that consumes a bit on every clock edge.

Parameters:
CODE_LEN, 6, number of bits per code entry; must match the lock sequence length.
DEBOUNCE_CYC, 4, consecutive stable-high synchronised cycles required to register a press (minimum 2).
TIMEOUT_CYC, 255, idle cycles after which a partial entry is discarded (used only with the optional feature).

Ports:
clk  in  1  system clock; the block acts on posedge; the lock samples on negedge, so outputs are stable half a cycle before use.
clear  in  1  asynchronous active-low reset.
key0  in  1  raw asynchronous button, active-high, enters a 0.
key1  in  1  raw asynchronous button, active-high, enters a 1.
b_out  out  1  serial code bit to the lock's b_in.
dl_clear  out  1  active-low clear to the lock.
busy  out  1  high in CLR and SEND; button presses are ignored while high.
digits  out  clog2(CODE_LEN+1)  number of bits collected in the current entry.

Behaviour:
- Reset (clear=0, asynchronous): state=IDLE, b_out=0, dl_clear=0, busy=0, digits=0, shift register=0, debounce counters=0, synchronisers=0.
- dl_clear is 0 during reset and in CLR, and 1 otherwise.
  - The lock is therefore released one posedge after reset deassertion.
  - The lock result (unlock) stays visible until the next entry's CLR.
- Input conditioning: each key passes a 2-flop synchroniser, then a saturating counter.
  - The counter increments while the synchronised key is high and resets to 0 when it is low.
  - A press is a 1-cycle pulse generated when the counter reaches DEBOUNCE_CYC.
  - At most one press is generated per high period.
  - Press latency is 2 + DEBOUNCE_CYC cycles from the raw rising edge.
- Simultaneous press pulses on key0 and key1 in the same cycle: both are discarded and digits is unchanged.
- Presses in CLR, SEND or DONE are discarded; their debounce state still runs, so a held key does not re-fire later.
- FSM states:
  - IDLE: on a press pulse, shift the bit into the LSB of the shift register and increment digits. The cycle that makes digits==CODE_LEN moves the FSM to CLR.
  - CLR (1 cycle): dl_clear=0, busy=1, b_out=0.
  - SEND (CODE_LEN cycles): busy=1, b_out = bit index CODE_LEN-1-k in cycle k (first press first). An internal counter runs from 0 to CODE_LEN-1.
  - DONE (1 cycle): b_out=0, digits cleared to 0, shift register cleared, busy=0. Next state is IDLE.
- Timing: CLR begins 1 cycle after the last press pulse, and the last SEND bit is driven CODE_LEN+1 cycles after that press. b_out is a registered output.
- Reset mid-SEND: the burst is aborted immediately, all outputs take their reset values, and nothing is resent.

Optional Feature:
Macro DLOCK_ENTRY_TIMEOUT_EN.
- Defined: an idle counter runs in IDLE while 0 < digits < CODE_LEN and restarts on every accepted press. When it reaches TIMEOUT_CYC, digits and the shift register clear to 0 in that cycle and no burst is sent.
- Undefined: there is no counter, partial entries persist indefinitely, and the TIMEOUT_CYC parameter is ignored.

Decomposition:
- Package dlock_pkg: FSM state encoding (IDLE=2'd0, CLR=2'd1, SEND=2'd2, DONE=2'd3) and the shared default DLOCK_CODE_LEN=6, used by both this block and the lock.
- Sub-module key_debounce (synchroniser, counter, press pulse; parameter DEBOUNCE_CYC), instantiated once per key.

Test Plan:
1. Clean presses 1,0,1,1,0,0 (each held 8 cycles, 8-cycle gaps): dl_clear=0 for exactly 1 cycle, then b_out=1,0,1,1,0,0 on 6 consecutive cycles. With the lock attached, unlock=1 after the sixth negedge and stays 1 through IDLE.
2. Bounce: key1 high for 2 cycles, low for 1, high for 3: no press and digits stays 0. A subsequent 6-cycle hold gives exactly one press and digits=1.
3. key0 and key1 raised in the same cycle and held 8 cycles: no press and digits unchanged. A single key held 20 cycles registers only 1 press.
4. Presses issued during SEND: the burst is unchanged, and digits=0 after DONE.
5. Reset asserted in SEND cycle 3: b_out=0, dl_clear=0 and busy=0 immediately. After release, dl_clear=1 on the next posedge and no further burst occurs.
6. With DLOCK_ENTRY_TIMEOUT_EN and TIMEOUT_CYC=20: 3 presses then 20 idle cycles gives digits=0. Without the macro, digits=3 persists and 3 more presses produce a burst of all 6 bits.
